spi_slave_fl: RTL and testbench

//  SPI slave (responder) for the spi_master_fl flash-style link, in the system clk domain.

---
 rtl/spi_slave_fl_pkg.sv | 21 ++
 rtl/spi_slave_fl_sync_edge.sv | 32 +++
 rtl/spi_slave_fl.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave_fl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_fl_pkg.sv
// Shared definitions for the spi_slave_fl responder: byte width, FSM states
// and the CPHA-dependent sample/shift edge selection.
package spi_slave_fl_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic sample_edge(input logic cpha, input logic lead, input logic trail);
        return cpha ? trail : lead;
    endfunction

    function automatic logic shift_edge(input logic cpha, input logic lead, input logic trail);
        return cpha ? lead : trail;
    endfunction

endpackage

// File: rtl/spi_slave_fl_sync_edge.sv
// N-stage synchronizer for an asynchronous input plus one-clk rise/fall pulses
// derived from the last stage against its previous value.
module spi_slave_fl_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_fl.sv
// SPI responder in the system clock domain: oversampled sclk/ss/mosi, MSB-first
// byte receive, tx shifter fed from a one-entry holding buffer.
module spi_slave_fl
    import spi_slave_fl_pkg::*;
#(
    parameter bit CPOL        = 1'b1,
    parameter bit CPHA        = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  ss_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [SPI_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  rx_first_o,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  frame_start_o,
    output logic                  frame_end_o,
    output logic                  frame_abort_o,
    output logic                  tx_underrun_o,
    output spi_state_e            state_o
);

    // tx_data_i/tx_valid_i/tx_ready_o: a byte moves into the responder in every
    // clk where tx_valid_i & tx_ready_o; tx_data_i must be stable while tx_valid_i is high.

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_mosi_edges;

    spi_slave_fl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_slave_fl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ss_i),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_slave_fl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sclk_s;

    logic lead_ev, trail_ev, sample_ev, shift_ev;
    assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
    assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
    assign sample_ev = sample_edge(CPHA, lead_ev, trail_ev);
    assign shift_ev  = shift_edge(CPHA, lead_ev, trail_ev);

    spi_state_e            state_q, state_d;
    logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic                  first_q, first_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_first_q, rx_first_d;
    logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BYTE_W-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_end_q, frame_end_d;
    logic                  frame_abort_q, frame_abort_d;
    logic                  tx_underrun_q, tx_underrun_d;
    logic                  load_c;
    logic                  accept_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            rx_shift_q    <= '0;
            bitcnt_q      <= '0;
            first_q       <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            tx_shift_q    <= '1;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_shift_q    <= rx_shift_d;
            bitcnt_q      <= bitcnt_d;
            first_q       <= first_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_first_q    <= rx_first_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_abort_q <= frame_abort_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rx_shift_d    = rx_shift_q;
        bitcnt_d      = bitcnt_q;
        first_d       = first_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_first_d    = 1'b0;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_abort_d = 1'b0;
        tx_underrun_d = 1'b0;
        load_c        = 1'b0;
        accept_c      = tx_valid_i & ~hold_full_q;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d       = ST_ACTIVE;
                    frame_start_d = 1'b1;
                    first_d       = 1'b1;
                    bitcnt_d      = '0;
                    load_c        = ~CPHA;
                end
            end
            ST_ACTIVE: begin
                // ss rising wins over any sclk edge detected in the same clk.
                if (ss_rise) begin
                    state_d       = ST_IDLE;
                    frame_end_d   = 1'b1;
                    frame_abort_d = (bitcnt_q != 3'd0);
                    bitcnt_d      = '0;
                end else begin
                    if (sample_ev) begin
                        rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                        bitcnt_d   = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_d  = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                        end
                    end
                    if (shift_ev) begin
                        if (bitcnt_q == 3'd0) begin
                            load_c = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b1};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte offered in the load clk bypasses the empty buffer.
        if (load_c) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else if (accept_c) begin
                tx_shift_d = tx_data_i;
            end else begin
                tx_shift_d    = '1;
                tx_underrun_d = 1'b1;
            end
        end else if (accept_c) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end
    end

    assign miso_o        = (state_q == ST_ACTIVE) ? tx_shift_q[SPI_BYTE_W-1] : 1'b1;
    assign miso_oe_o     = (state_q == ST_ACTIVE) & ~ss_s;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_first_o    = rx_first_q;
    assign tx_ready_o    = ~hold_full_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign frame_abort_o = frame_abort_q;
    assign tx_underrun_o = tx_underrun_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_spi_slave_fl.sv
// Bench for spi_slave_fl: a mode 3 and a mode 0 instance driven by a bit-level
// SPI master task, checked against a byte-level model of loads and receives.
module tb_spi_slave_fl;

    localparam int H    = 8;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: CPOL=1/CPHA=1 instance, index 1: CPOL=0/CPHA=0 instance
    logic       rst[2];
    logic       sclk[2];
    logic       ss[2];
    logic       mosi[2];
    logic       tx_valid[2];
    logic [7:0] tx_data[2];
    logic       miso[2];
    logic       miso_oe[2];
    logic [7:0] rx_data[2];
    logic       rx_valid[2];
    logic       rx_first[2];
    logic       tx_ready[2];
    logic       fs[2];
    logic       fe[2];
    logic       fa[2];
    logic       ur[2];
    spi_slave_fl_pkg::spi_state_e st[2];

    spi_slave_fl #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut_m3 (
        .clk_i(clk), .rst_i(rst[0]), .sclk_i(sclk[0]), .ss_i(ss[0]), .mosi_i(mosi[0]),
        .miso_o(miso[0]), .miso_oe_o(miso_oe[0]), .rx_data_o(rx_data[0]),
        .rx_valid_o(rx_valid[0]), .rx_first_o(rx_first[0]), .tx_data_i(tx_data[0]),
        .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]), .frame_start_o(fs[0]),
        .frame_end_o(fe[0]), .frame_abort_o(fa[0]), .tx_underrun_o(ur[0]), .state_o(st[0])
    );

    spi_slave_fl #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut_m0 (
        .clk_i(clk), .rst_i(rst[1]), .sclk_i(sclk[1]), .ss_i(ss[1]), .mosi_i(mosi[1]),
        .miso_o(miso[1]), .miso_oe_o(miso_oe[1]), .rx_data_o(rx_data[1]),
        .rx_valid_o(rx_valid[1]), .rx_first_o(rx_first[1]), .tx_data_i(tx_data[1]),
        .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]), .frame_start_o(fs[1]),
        .frame_end_o(fe[1]), .frame_abort_o(fa[1]), .tx_underrun_o(ur[1]), .state_o(st[1])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard entries: {instance, first flag, byte}
    logic [9:0] exp_q[$];
    logic [7:0] host_q0[$], host_q1[$];
    logic [7:0] mdl_q0[$], mdl_q1[$];
    logic [7:0] mo_buf[MAXB];
    logic [7:0] mi_buf[MAXB];
    int cnt_fs[2], cnt_fe[2], cnt_ab[2], cnt_ur[2];

    always @(negedge clk) begin : mon
        logic [9:0] e;
        for (int s = 0; s < 2; s++) begin
            if (!rst[s]) begin
                if (rx_valid[s]) begin
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_valid", 32'(rx_valid[s]), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_port", 32'(s), 32'(e[9]));
                        check("rx_data", 32'(rx_data[s]), 32'(e[7:0]));
                        check("rx_first", 32'(rx_first[s]), 32'(e[8]));
                    end
                end
                if (fa[s]) check("abort_with_end", 32'(fe[s]), 32'd1);
                if (fs[s]) cnt_fs[s]++;
                if (fe[s]) cnt_fe[s]++;
                if (fa[s]) cnt_ab[s]++;
                if (ur[s]) cnt_ur[s]++;
            end
        end
    end

    // host: offer the next queued byte whenever the buffer is free
    always @(negedge clk) begin
        if (tx_valid[0]) tx_valid[0] = 1'b0;
        else if (host_q0.size() > 0 && tx_ready[0] && !rst[0]) begin
            tx_data[0]  = host_q0.pop_front();
            tx_valid[0] = 1'b1;
        end
        if (tx_valid[1]) tx_valid[1] = 1'b0;
        else if (host_q1.size() > 0 && tx_ready[1] && !rst[1]) begin
            tx_data[1]  = host_q1.pop_front();
            tx_valid[1] = 1'b1;
        end
    end

    task automatic supply(input int sel, input logic [7:0] b);
        if (sel == 0) begin host_q0.push_back(b); mdl_q0.push_back(b); end
        else          begin host_q1.push_back(b); mdl_q1.push_back(b); end
    endtask

    task automatic check_reset(input int sel, input string pfx);
        check({pfx, "_miso"}, 32'(miso[sel]), 32'd1);
        check({pfx, "_miso_oe"}, 32'(miso_oe[sel]), 32'd0);
        check({pfx, "_rx_data"}, 32'(rx_data[sel]), 32'd0);
        check({pfx, "_rx_valid"}, 32'(rx_valid[sel]), 32'd0);
        check({pfx, "_rx_first"}, 32'(rx_first[sel]), 32'd0);
        check({pfx, "_tx_ready"}, 32'(tx_ready[sel]), 32'd1);
        check({pfx, "_pulses"}, 32'({fs[sel], fe[sel], fa[sel], ur[sel]}), 32'd0);
        check({pfx, "_state"}, 32'(st[sel]), 32'd0);
    endtask

    // bit-level master; optional reset injected at the start of bit rst_bit
    task automatic spi_frame(input int sel, input int nbits, input int rst_bit);
        logic cpol, cpha, b_in;
        int   by, bi;
        cpol = (sel == 0);
        cpha = (sel == 0);
        for (int k = 0; k < MAXB; k++) mi_buf[k] = 8'h00;
        mosi[sel] = mo_buf[0][7];
        @(negedge clk);
        ss[sel] = 1'b0;
        repeat (H) @(negedge clk);
        check("miso_oe_active", 32'(miso_oe[sel]), 32'd1);
        for (int b = 0; b < nbits; b++) begin
            by = b / 8;
            bi = 7 - (b % 8);
            if (b == rst_bit) begin
                rst[sel] = 1'b1;
                @(negedge clk);
                check_reset(sel, "midrst");
                ss[sel]   = 1'b1;
                sclk[sel] = cpol;
                repeat (4) @(negedge clk);
                rst[sel] = 1'b0;
                repeat (H) @(negedge clk);
                return;
            end
            if (!cpha) begin
                b_in      = miso[sel];
                sclk[sel] = ~cpol;
                repeat (H) @(negedge clk);
                sclk[sel] = cpol;
                if (b + 1 < nbits) mosi[sel] = mo_buf[(b + 1) / 8][7 - ((b + 1) % 8)];
                repeat (H) @(negedge clk);
            end else begin
                sclk[sel] = ~cpol;
                mosi[sel] = mo_buf[by][bi];
                repeat (H) @(negedge clk);
                b_in      = miso[sel];
                sclk[sel] = cpol;
                repeat (H) @(negedge clk);
            end
            mi_buf[by][bi] = b_in;
        end
        ss[sel] = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    // Model: every shifter load takes the oldest supplied byte, else 0xFF with an
    // underrun. Mode 3 loads once per started byte; mode 0 loads at frame start
    // and after every complete byte.
    task automatic run_frame(input int sel, input int nbytes, input int partial, input int rst_bit);
        int         loads, ur_exp, fs0, fe0, ab0, ur0;
        logic [7:0] exp_mi[MAXB];
        ur_exp = 0;
        if (rst_bit >= 0) loads = 0;
        else if (sel == 1) loads = nbytes + 1;
        else loads = nbytes + ((partial > 0) ? 1 : 0);
        for (int k = 0; k < MAXB; k++) exp_mi[k] = 8'hFF;
        for (int k = 0; k < loads; k++) begin
            if (sel == 0 && mdl_q0.size() > 0) exp_mi[k] = mdl_q0.pop_front();
            else if (sel == 1 && mdl_q1.size() > 0) exp_mi[k] = mdl_q1.pop_front();
            else ur_exp++;
        end
        if (rst_bit < 0)
            for (int k = 0; k < nbytes; k++) exp_q.push_back({sel[0], (k == 0), mo_buf[k]});
        repeat (4) @(negedge clk);
        fs0 = cnt_fs[sel]; fe0 = cnt_fe[sel]; ab0 = cnt_ab[sel]; ur0 = cnt_ur[sel];
        spi_frame(sel, nbytes * 8 + partial, rst_bit);
        if (rst_bit < 0) begin
            check("frame_start_cnt", 32'(cnt_fs[sel] - fs0), 32'd1);
            check("frame_end_cnt", 32'(cnt_fe[sel] - fe0), 32'd1);
            check("frame_abort_cnt", 32'(cnt_ab[sel] - ab0), 32'((partial > 0) ? 1 : 0));
            check("tx_underrun_cnt", 32'(cnt_ur[sel] - ur0), 32'(ur_exp));
            for (int k = 0; k < nbytes; k++) check("miso_byte", 32'(mi_buf[k]), 32'(exp_mi[k]));
        end
        check("rx_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        sclk[0] = 1'b1; sclk[1] = 1'b0;
        ss[0] = 1'b1; ss[1] = 1'b1;
        mosi[0] = 1'b0; mosi[1] = 1'b0;
        tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
        tx_data[0] = 8'h00; tx_data[1] = 8'h00;
        for (int s = 0; s < 2; s++) begin
            cnt_fs[s] = 0; cnt_fe[s] = 0; cnt_ab[s] = 0; cnt_ur[s] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset(0, "rst_m3");
        check_reset(1, "rst_m0");
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (4) @(negedge clk);

        // mode 3: single command byte with a preloaded reply
        supply(0, 8'hA5);
        mo_buf[0] = 8'h9F;
        run_frame(0, 1, 0, -1);

        // burst: five bytes, four supplied, last one underruns
        supply(0, 8'h5C); supply(0, 8'h11); supply(0, 8'h22); supply(0, 8'h33);
        mo_buf[0] = 8'h03; mo_buf[1] = 8'h12; mo_buf[2] = 8'h34; mo_buf[3] = 8'h56; mo_buf[4] = 8'h00;
        run_frame(0, 5, 0, -1);

        // abort after 5 bits, then a clean byte with an empty buffer
        mo_buf[0] = 8'hB7;
        run_frame(0, 0, 5, -1);
        mo_buf[0] = 8'h5A;
        run_frame(0, 1, 0, -1);

        // reset in the middle of a byte, then a fresh frame
        mo_buf[0] = 8'hF0;
        run_frame(0, 1, 0, 4);
        mo_buf[0] = 8'h01;
        run_frame(0, 1, 0, -1);

        for (int f = 0; f < 10; f++) begin
            int nb, pb, ns;
            nb = $urandom_range(1, 4);
            pb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            ns = $urandom_range(0, 5);
            for (int k = 0; k < ns; k++) supply(0, 8'($urandom));
            for (int k = 0; k < MAXB; k++) mo_buf[k] = 8'($urandom);
            run_frame(0, nb, pb, -1);
        end

        // mode 0: first bit must already be on miso before the first sclk edge
        supply(1, 8'hC3);
        mo_buf[0] = 8'h6E;
        run_frame(1, 1, 0, -1);

        for (int f = 0; f < 10; f++) begin
            int nb, pb, ns;
            nb = $urandom_range(1, 4);
            pb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            ns = $urandom_range(0, 5);
            for (int k = 0; k < ns; k++) supply(1, 8'($urandom));
            for (int k = 0; k < MAXB; k++) mo_buf[k] = 8'($urandom);
            run_frame(1, nb, pb, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
